// File: rtl/fifo_pkg.sv
// Shared helpers and types for the single-clock FIFO family.
package fifo_pkg;

    typedef enum logic {
        RD_NORMAL    = 1'b0,
        RD_SHOWAHEAD = 1'b1
    } rd_mode_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int v = value - 1; v > 0; v = v >> 1) begin
            r = r + 1;
        end
        return r;
    endfunction

    function automatic int depth_of(input int awidth);
        return 1 << awidth;
    endfunction

endpackage

// File: rtl/fifo_sc_ram.sv
// Simple dual-port RAM: one write port, one registered read port (read-first on address collision).
module fifo_sc_ram
    import fifo_pkg::*;
#(
    parameter int DWIDTH = 16,
    parameter int AWIDTH = 8
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wr_en_i,
    input  logic [AWIDTH-1:0] wr_addr_i,
    input  logic [DWIDTH-1:0] wr_dat_i,
    input  logic              rd_en_i,
    input  logic [AWIDTH-1:0] rd_addr_i,
    output logic [DWIDTH-1:0] rd_dat_o
);

    localparam int DEPTH = depth_of(AWIDTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd_dat_q;

    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_dat_i;
        end
    end

    // Only the output register is reset so q_o has a defined value; the array stays reset-free.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_dat_q <= '0;
        end else if (rd_en_i) begin
            rd_dat_q <= mem_q[rd_addr_i];
        end
    end

    assign rd_dat_o = rd_dat_q;

endmodule

// File: rtl/fifo_sc.sv
// Single-clock FIFO with showahead/normal read, 0..DEPTH occupancy, flush and sticky error flags.
// Showahead hides the RAM read latency with a bypass/prefetch register holding the head word.
module fifo_sc
    import fifo_pkg::*;
#(
    parameter int DWIDTH             = 16,
    parameter int AWIDTH             = 8,
    parameter int SHOWAHEAD          = 1,
    parameter int ALMOST_FULL_VALUE  = 240,
    parameter int ALMOST_EMPTY_VALUE = 15
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              flush_i,
    input  logic [DWIDTH-1:0] data_i,
    input  logic              wrreq_i,
    input  logic              rdreq_i,
    input  logic              clr_err_i,
    output logic [DWIDTH-1:0] q_o,
    output logic              empty_o,
    output logic              full_o,
    output logic [AWIDTH:0]   usedw_o,
    output logic              almost_full_o,
    output logic              almost_empty_o,
    output logic              ovf_o,
    output logic              udf_o
);

    localparam int       DEPTH = depth_of(AWIDTH);
    localparam int       CNT_W = clog2(DEPTH + 1);
    localparam rd_mode_e MODE  = (SHOWAHEAD != 0) ? RD_SHOWAHEAD : RD_NORMAL;

    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AF_TH   = CNT_W'(ALMOST_FULL_VALUE);
    localparam logic [CNT_W-1:0] AE_TH   = CNT_W'(ALMOST_EMPTY_VALUE);

    logic [AWIDTH-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              empty_q, full_q, afull_q, aempty_q;
    logic              ovf_q, ovf_d, udf_q, udf_d;
    logic              sel_byp_q, sel_byp_d;
    logic [DWIDTH-1:0] byp_q, byp_d;
    logic [DWIDTH-1:0] ram_dat;
    logic              rd_ok, wr_ok;

    assign rd_ok = ~flush_i & rdreq_i & ~empty_q;
    assign wr_ok = ~flush_i & wrreq_i & (~full_q | rd_ok);
    assign ovf_d = (ovf_q & ~clr_err_i) | (~flush_i & wrreq_i & ~wr_ok);
    assign udf_d = (udf_q & ~clr_err_i) | (~flush_i & rdreq_i & ~rd_ok);

    always_comb begin
        wr_ptr_d = wr_ptr_q + AWIDTH'(wr_ok);
        rd_ptr_d = rd_ptr_q + AWIDTH'(rd_ok);
        cnt_d    = cnt_q;
        if (wr_ok && !rd_ok) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (rd_ok && !wr_ok) begin
            cnt_d = cnt_q - CNT_W'(1);
        end
        if (flush_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            cnt_d    = '0;
        end
    end

    // The RAM in showahead mode always reads the next head address, so its output tracks the head
    // one cycle later; the bypass covers the only cases where that slot was written in this cycle.
    always_comb begin
        sel_byp_d = sel_byp_q;
        byp_d     = byp_q;
        if (MODE == RD_SHOWAHEAD) begin
            if (cnt_d == '0) begin
                sel_byp_d = 1'b1;
                byp_d     = q_o;
            end else if (wr_ok && (cnt_q == CNT_W'(rd_ok))) begin
                sel_byp_d = 1'b1;
                byp_d     = data_i;
            end else if (rd_ok) begin
                sel_byp_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            cnt_q     <= '0;
            empty_q   <= 1'b1;
            full_q    <= 1'b0;
            afull_q   <= 1'b0;
            aempty_q  <= 1'b1;
            ovf_q     <= 1'b0;
            udf_q     <= 1'b0;
            sel_byp_q <= 1'b1;
            byp_q     <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            cnt_q     <= cnt_d;
            empty_q   <= (cnt_d == '0);
            full_q    <= (cnt_d == CNT_MAX);
            afull_q   <= (cnt_d >= AF_TH);
            aempty_q  <= (cnt_d < AE_TH);
            ovf_q     <= ovf_d;
            udf_q     <= udf_d;
            sel_byp_q <= sel_byp_d;
            byp_q     <= byp_d;
        end
    end

    fifo_sc_ram #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH)
    ) u_ram (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .wr_en_i   (wr_ok),
        .wr_addr_i (wr_ptr_q),
        .wr_dat_i  (data_i),
        .rd_en_i   ((MODE == RD_SHOWAHEAD) ? 1'b1 : rd_ok),
        .rd_addr_i ((MODE == RD_SHOWAHEAD) ? rd_ptr_d : rd_ptr_q),
        .rd_dat_o  (ram_dat)
    );

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            assert (cnt_q <= CNT_MAX);
            assert (MODE == RD_SHOWAHEAD || sel_byp_q);
        end
    end

    assign q_o            = (MODE == RD_SHOWAHEAD && sel_byp_q) ? byp_q : ram_dat;
    assign empty_o        = empty_q;
    assign full_o         = full_q;
    assign usedw_o        = cnt_q;
    assign almost_full_o  = afull_q;
    assign almost_empty_o = aempty_q;
    assign ovf_o          = ovf_q;
    assign udf_o          = udf_q;

endmodule

// File: tb/tb_fifo_sc.sv
// Scoreboard bench: one stimulus stream drives a showahead and a normal-mode FIFO side by side.
module tb_fifo_sc;

    localparam int DW    = 16;
    localparam int AW    = 3;
    localparam int DEPTH = 8;
    localparam int AFV   = 6;
    localparam int AEV   = 2;

    logic          clk = 1'b0;
    logic          rst, flush, wrreq, rdreq, clr_err;
    logic [DW-1:0] din;

    logic [DW-1:0] q_sa, q_nm;
    logic          empty_sa, full_sa, af_sa, ae_sa, ovf_sa, udf_sa;
    logic          empty_nm, full_nm, af_nm, ae_nm, ovf_nm, udf_nm;
    logic [AW:0]   usedw_sa, usedw_nm;

    always #5 clk = ~clk;

    fifo_sc #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(1),
              .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)) u_sa (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .wrreq_i(wrreq),
        .rdreq_i(rdreq), .clr_err_i(clr_err), .q_o(q_sa), .empty_o(empty_sa),
        .full_o(full_sa), .usedw_o(usedw_sa), .almost_full_o(af_sa),
        .almost_empty_o(ae_sa), .ovf_o(ovf_sa), .udf_o(udf_sa));

    fifo_sc #(.DWIDTH(DW), .AWIDTH(AW), .SHOWAHEAD(0),
              .ALMOST_FULL_VALUE(AFV), .ALMOST_EMPTY_VALUE(AEV)) u_nm (
        .clk_i(clk), .rst_i(rst), .flush_i(flush), .data_i(din), .wrreq_i(wrreq),
        .rdreq_i(rdreq), .clr_err_i(clr_err), .q_o(q_nm), .empty_o(empty_nm),
        .full_o(full_nm), .usedw_o(usedw_nm), .almost_full_o(af_nm),
        .almost_empty_o(ae_nm), .ovf_o(ovf_nm), .udf_o(udf_nm));

    typedef struct {
        int            cnt;
        bit            ovf;
        bit            udf;
        logic [DW-1:0] qn;
        logic [DW-1:0] head;
    } stat_t;

    stat_t         stat_q[$];
    logic [DW-1:0] exp_sa[$];
    logic [DW-1:0] exp_nm[$];
    logic [DW-1:0] mq[$];
    bit            m_ovf, m_udf;
    logic [DW-1:0] m_qnm;
    bit            nm_pend;
    int            checks = 0;
    int            errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a plain word queue plus accept rules; expected read data is queued on issue.
    task automatic cyc(input bit wr, input bit rd, input logic [DW-1:0] d, input bit fl, input bit ce);
        stat_t s;
        bit    rd_ok, wr_ok;
        int    cnt;
        @(posedge clk);
        #1;
        s.cnt  = mq.size();
        s.ovf  = m_ovf;
        s.udf  = m_udf;
        s.qn   = m_qnm;
        s.head = (mq.size() > 0) ? mq[0] : '0;
        stat_q.push_back(s);
        wrreq = wr; rdreq = rd; din = d; flush = fl; clr_err = ce;
        cnt   = mq.size();
        rd_ok = !fl && rd && cnt > 0;
        wr_ok = !fl && wr && (cnt < DEPTH || rd_ok);
        if (rd_ok) begin
            m_qnm = mq.pop_front();
            exp_sa.push_back(m_qnm);
            exp_nm.push_back(m_qnm);
        end
        if (wr_ok) mq.push_back(d);
        if (fl) mq.delete();
        m_ovf = (m_ovf && !ce) || (!fl && wr && !wr_ok);
        m_udf = (m_udf && !ce) || (!fl && rd && !rd_ok);
    endtask

    task automatic async_reset();
        @(posedge clk);
        #3;
        rst = 1'b1; wrreq = 1'b0; rdreq = 1'b0; flush = 1'b0; clr_err = 1'b0;
        stat_q.delete(); exp_sa.delete(); exp_nm.delete(); mq.delete();
        m_ovf = 1'b0; m_udf = 1'b0; m_qnm = '0;
        #1;
        chk("rst_usedw_sa", int'(usedw_sa), 0);
        chk("rst_empty_sa", int'(empty_sa), 1);
        chk("rst_q_sa", int'(q_sa), 0);
        chk("rst_full_sa", int'(full_sa), 0);
        chk("rst_ae_sa", int'(ae_sa), 1);
        chk("rst_af_sa", int'(af_sa), 0);
        chk("rst_usedw_nm", int'(usedw_nm), 0);
        chk("rst_empty_nm", int'(empty_nm), 1);
        chk("rst_q_nm", int'(q_nm), 0);
        @(posedge clk);
        #2;
        rst = 1'b0;
    endtask

    always @(negedge clk) begin
        stat_t s;
        if (rst) begin
            nm_pend = 1'b0;
        end else begin
            if (nm_pend) begin
                if (exp_nm.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL nm_read at %0t: q_o=0x%0h but no read was pending", $time, q_nm);
                end else begin
                    chk("nm_read_data", int'(q_nm), int'(exp_nm.pop_front()));
                end
            end
            nm_pend = rdreq && !flush && !empty_nm;
            if (rdreq && !flush && !empty_sa) begin
                if (exp_sa.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL sa_read at %0t: q_o=0x%0h but no read was expected", $time, q_sa);
                end else begin
                    chk("sa_read_data", int'(q_sa), int'(exp_sa.pop_front()));
                end
            end
            if (stat_q.size() > 0) begin
                s = stat_q.pop_front();
                chk("sa_usedw", int'(usedw_sa), s.cnt);
                chk("sa_empty", int'(empty_sa), int'(s.cnt == 0));
                chk("sa_full", int'(full_sa), int'(s.cnt == DEPTH));
                chk("sa_almost_full", int'(af_sa), int'(s.cnt >= AFV));
                chk("sa_almost_empty", int'(ae_sa), int'(s.cnt < AEV));
                chk("sa_ovf", int'(ovf_sa), int'(s.ovf));
                chk("sa_udf", int'(udf_sa), int'(s.udf));
                if (s.cnt > 0) chk("sa_head", int'(q_sa), int'(s.head));
                chk("nm_usedw", int'(usedw_nm), s.cnt);
                chk("nm_empty", int'(empty_nm), int'(s.cnt == 0));
                chk("nm_full", int'(full_nm), int'(s.cnt == DEPTH));
                chk("nm_almost_full", int'(af_nm), int'(s.cnt >= AFV));
                chk("nm_almost_empty", int'(ae_nm), int'(s.cnt < AEV));
                chk("nm_ovf", int'(ovf_nm), int'(s.ovf));
                chk("nm_udf", int'(udf_nm), int'(s.udf));
                chk("nm_q_hold", int'(q_nm), int'(s.qn));
            end
        end
    end

    initial begin
        int wp, rp;
        rst = 1'b1; flush = 1'b0; wrreq = 1'b0; rdreq = 1'b0; clr_err = 1'b0; din = '0;
        m_ovf = 1'b0; m_udf = 1'b0; m_qnm = '0; nm_pend = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        for (int i = 0; i < 5; i++) cyc(1, 0, DW'($urandom), 0, 0);
        async_reset();

        for (int i = 1; i <= 8; i++) cyc(1, 0, DW'(i), 0, 0);
        cyc(0, 0, '0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);

        for (int i = 0; i < 8; i++) cyc(1, 0, DW'($urandom), 0, 0);
        for (int i = 0; i < 20; i++) cyc(1, 1, DW'($urandom), 0, 0);
        cyc(1, 0, 16'hdead, 0, 0);
        cyc(0, 0, '0, 0, 0);
        for (int i = 0; i < 8; i++) cyc(0, 1, '0, 0, 0);
        cyc(0, 1, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        cyc(0, 0, '0, 0, 1);
        cyc(0, 0, '0, 0, 0);

        cyc(1, 1, 16'h5555, 0, 0);
        cyc(0, 0, '0, 0, 1);
        cyc(0, 1, '0, 0, 0);

        cyc(1, 0, 16'haaaa, 0, 0);
        cyc(1, 0, 16'hbbbb, 0, 0);
        cyc(0, 0, '0, 0, 0);
        cyc(0, 1, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);
        cyc(0, 1, '0, 0, 0);
        cyc(0, 0, '0, 0, 0);

        for (int i = 0; i < 9; i++) cyc(1, 0, DW'($urandom), 0, 0);
        for (int i = 0; i < 4; i++) cyc(0, 1, '0, 0, 0);
        cyc(0, 0, '0, 1, 0);
        cyc(1, 0, 16'h1234, 0, 0);
        cyc(0, 0, '0, 0, 0);
        cyc(0, 1, '0, 0, 1);
        cyc(0, 0, '0, 0, 0);

        for (int p = 0; p < 12; p++) begin
            wp = (p % 3 == 0) ? 80 : (p % 3 == 1) ? 30 : 60;
            rp = (p % 3 == 0) ? 30 : (p % 3 == 1) ? 80 : 60;
            for (int i = 0; i < 250; i++) begin
                cyc($urandom_range(99) < wp, $urandom_range(99) < rp, DW'($urandom),
                    $urandom_range(63) == 0, $urandom_range(31) == 0);
            end
        end

        for (int i = 0; i < 10; i++) cyc(0, 1, '0, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, '0, 0, 0);
        @(posedge clk);
        #2;
        chk("sa_reads_outstanding", exp_sa.size(), 0);
        chk("nm_reads_outstanding", exp_nm.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fifo_sc.md
Name: fifo_sc

Overview:
- Self-contained single-clock FIFO. It replaces the vendor-IP FIFO wrapper with portable RTL.
- Adds selectable showahead/normal read mode, full-range occupancy count, synchronous flush, and sticky overflow/underflow error flags.
- Sits between producer and consumer stages within one clock domain.
- Is the team's reference model for all later FIFO variants.

Parameters:
- DWIDTH, 16, data word width (>=1).
- AWIDTH, 8, address width; DEPTH = 2**AWIDTH words (AWIDTH >= 2).
- SHOWAHEAD, 1: 1 = head word presented on q_o before rdreq_i; 0 = q_o updates after rdreq_i.
- ALMOST_FULL_VALUE, 240, almost_full_o threshold (1..DEPTH).
- ALMOST_EMPTY_VALUE, 15, almost_empty_o threshold (1..DEPTH).

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset: asynchronous, active-high.
- flush_i  in  1  synchronous clear of contents; has priority over wrreq_i/rdreq_i.
- data_i  in  DWIDTH  write data.
- wrreq_i  in  1  write request.
- rdreq_i  in  1  read request (showahead: acknowledge/pop head).
- clr_err_i  in  1  synchronous clear of ovf_o/udf_o.
- q_o  out  DWIDTH  read data.
- empty_o  out  1  no words stored.
- full_o  out  1  DEPTH words stored.
- usedw_o  out  AWIDTH+1  occupancy, 0..DEPTH inclusive.
- almost_full_o  out  1  usedw_o >= ALMOST_FULL_VALUE.
- almost_empty_o  out  1  usedw_o < ALMOST_EMPTY_VALUE.
- ovf_o  out  1  sticky: a write was rejected.
- udf_o  out  1  sticky: a read was rejected.

Behaviour:
- Reset (async assert, sync deassert is the integrator's job): wr/rd pointers = 0, usedw_o = 0, empty_o = 1, full_o = 0, almost_empty_o = 1, almost_full_o = 0, q_o = 0, ovf_o = udf_o = 0.
- Asserting rst_i mid-transfer discards all contents immediately.
- Read accepted (rd_ok) = rdreq_i && !empty_o.
- Write accepted (wr_ok) = wrreq_i && (!full_o || rd_ok). When full, a simultaneous read and write are both accepted and usedw_o stays DEPTH.
- Empty plus simultaneous wrreq_i/rdreq_i: write accepted, read rejected, udf_o set.
- Pointers are AWIDTH bits and wrap naturally at DEPTH-1 -> 0.
- usedw_o is a registered counter: +1 on wr_ok only, -1 on rd_ok only, unchanged on both or neither.
- All status flags are registered and derived from the next-state count, so they are valid the same cycle as usedw_o.
- Rejected wrreq_i sets ovf_o; rejected rdreq_i sets udf_o. Both hold until clr_err_i or rst_i. If clr_err_i coincides with a new error, the flag stays set.
- flush_i: next cycle has the same state as reset except the error flags, which are kept. q_o holds its last value.
- SHOWAHEAD=1:
  - Word written in cycle N -> empty_o = 0 and q_o = that word from N+1.
  - After rd_ok in cycle M, q_o shows the next word (or holds the last value if now empty) from M+1.
  - Write to an empty FIFO requires a bypass path; the RAM read latency is hidden by a one-word prefetch register.
- SHOWAHEAD=0: rd_ok in cycle M -> q_o = popped word from M+1. Otherwise q_o holds.
- Empty state is not sampled on q_o: with SHOWAHEAD=1 and empty_o = 1, q_o value is don't-care for checking.
- Storage is inferred RAM with a registered read port. No read-during-write hazard may be visible at q_o.

Decomposition:
- Package fifo_pkg:
  - function clog2-style helpers.
  - localparam-style DEPTH computation.
  - enum for read mode (RD_NORMAL, RD_SHOWAHEAD) used in assertions.
- Sub-module fifo_sc_ram: simple dual-port RAM, one write port, one registered read port, parametrised DWIDTH/AWIDTH, no reset on the array.
- Top fifo_sc holds pointers, counter, flags, prefetch/bypass logic, and the error flags.

Test Plan:
- Reset mid-stream: write 5 words, assert rst_i asynchronously between clock edges -> outputs take their reset values immediately (usedw_o = 0, empty_o = 1, q_o = 0) without waiting for an edge.
- Fill/drain, AWIDTH=3, SHOWAHEAD=1: write 0x01..0x08 -> full_o = 1 and usedw_o = 8 after the 8th edge; almost flags switch at the thresholds. Then read 8 -> q_o sequence 0x01..0x08, empty_o = 1 after the last read.
- Wrap and simultaneous access: at usedw_o = 8 (full), assert wrreq_i and rdreq_i for 20 cycles -> usedw_o stays 8, full_o stays 1, data order preserved across pointer wrap, ovf_o = 0.
- Errors: write when full without read -> ovf_o = 1, usedw_o unchanged. Read when empty -> udf_o = 1. clr_err_i -> both 0 next cycle.
- SHOWAHEAD=0 latency: write 0xAAAA, 0xBBBB; rdreq_i in cycle M -> q_o = 0xAAAA at M+1; q_o holds until the next rdreq_i.
- Flush: with 4 words stored and ovf_o = 1, pulse flush_i -> usedw_o = 0, empty_o = 1, ovf_o still 1. A next write of 0x1234 appears on q_o one cycle later (SHOWAHEAD=1).
